// File: rtl/disp_mux.sv
// Multiplexed hex 7-segment display driver with tear-free double buffering
// and optional leading-zero blanking.
module disp_mux #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned DIV            = 1024,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_lz,
  output logic [6:0]            segments,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_done
);

  localparam int unsigned VW = 4 * DIGITS;
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [VW-1:0]     act_val_q, act_val_d, pnd_val_q, pnd_val_d;
  logic [DIGITS-1:0] act_dp_q, act_dp_d, pnd_dp_q, pnd_dp_d;
  logic              pnd_q, pnd_d;
  logic [6:0]        seg_q, seg_d;
  logic              segdp_q, segdp_d;
  logic [DIGITS-1:0] dsel_q, dsel_d;
  logic              fd_q, fd_d;

  logic              tick, last, boundary, blank, zsel, dpsel;
  logic [3:0]        nib;
  logic [DIGITS:0]   zabove;

  function automatic logic [6:0] dec7(input logic [3:0] n);
    case (n)
      4'h0:    dec7 = 7'b1111110;
      4'h1:    dec7 = 7'b0110000;
      4'h2:    dec7 = 7'b1101101;
      4'h3:    dec7 = 7'b1111001;
      4'h4:    dec7 = 7'b0110011;
      4'h5:    dec7 = 7'b1011011;
      4'h6:    dec7 = 7'b1011111;
      4'h7:    dec7 = 7'b1110000;
      4'h8:    dec7 = 7'b1111111;
      4'h9:    dec7 = 7'b1111011;
      4'hA:    dec7 = 7'b1110111;
      4'hB:    dec7 = 7'b0011111;
      4'hC:    dec7 = 7'b0001101;
      4'hD:    dec7 = 7'b0111101;
      4'hE:    dec7 = 7'b1001111;
      default: dec7 = 7'b1000111;
    endcase
  endfunction

  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    act_val_d = act_val_q;
    act_dp_d  = act_dp_q;
    pnd_val_d = pnd_val_q;
    pnd_dp_d  = pnd_dp_q;
    pnd_d     = pnd_q;
    seg_d     = '0;
    segdp_d   = 1'b0;
    dsel_d    = '0;
    nib       = '0;
    zsel      = 1'b0;
    dpsel     = 1'b0;
    zabove    = '0;

    tick     = en && (cnt_q == CW'(DIV - 1));
    last     = (idx_q == IW'(DIGITS - 1));
    boundary = tick && last;

    if (en) cnt_d = tick ? '0 : cnt_q + CW'(1);
    if (tick) idx_d = last ? '0 : idx_q + IW'(1);

    // Active data only changes while idle or on the frame boundary, so a frame never tears.
    if (!en) begin
      if (load) begin
        act_val_d = value;
        act_dp_d  = dp;
      end
    end else if (boundary) begin
      if (load) begin
        act_val_d = value;
        act_dp_d  = dp;
      end else if (pnd_q) begin
        act_val_d = pnd_val_q;
        act_dp_d  = pnd_dp_q;
      end
      pnd_d = 1'b0;
    end else if (load) begin
      pnd_val_d = value;
      pnd_dp_d  = dp;
      pnd_d     = 1'b1;
    end

    // zabove[i]: nibble i and every nibble above it are zero.
    zabove[DIGITS] = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zabove[i] = zabove[i+1] && (act_val_q[i*4 +: 4] == 4'h0);
    end

    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IW'(i)) begin
        nib   = act_val_q[i*4 +: 4];
        zsel  = zabove[i];
        dpsel = act_dp_q[i];
      end
    end
    blank = blank_lz && (idx_q != '0) && zsel;

    fd_d = boundary;
    if (en) begin
      for (int i = 0; i < int'(DIGITS); i++) dsel_d[i] = (idx_q == IW'(i));
      seg_d   = blank ? 7'b0000000 : dec7(nib);
      segdp_d = dpsel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      act_val_q <= '0;
      act_dp_q  <= '0;
      pnd_val_q <= '0;
      pnd_dp_q  <= '0;
      pnd_q     <= 1'b0;
      seg_q     <= '0;
      segdp_q   <= 1'b0;
      dsel_q    <= '0;
      fd_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      act_val_q <= act_val_d;
      act_dp_q  <= act_dp_d;
      pnd_val_q <= pnd_val_d;
      pnd_dp_q  <= pnd_dp_d;
      pnd_q     <= pnd_d;
      seg_q     <= seg_d;
      segdp_q   <= segdp_d;
      dsel_q    <= dsel_d;
      fd_q      <= fd_d;
    end
  end

  // Pin polarity is applied after the logical registers.
  assign segments   = seg_q ^ {7{SEG_ACTIVE_LOW}};
  assign seg_dp     = segdp_q ^ SEG_ACTIVE_LOW;
  assign digit_sel  = dsel_q ^ {DIGITS{DIG_ACTIVE_LOW}};
  assign frame_done = fd_q;

endmodule

// File: tb/tb_disp_mux.sv
// Scoreboard bench for disp_mux: stimulus queues cycle-stamped expected pin
// values; a negedge monitor compares them against the DUT.
module tb_disp_mux;

  logic        clk = 1'b0;
  logic        rst_n, en, load, blank_lz;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [6:0]  segments;
  logic        seg_dp, frame_done;
  logic [3:0]  digit_sel;

  localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101,
                         S5 = 7'b1011011, S8 = 7'b1111111, SA = 7'b1110111,
                         SF = 7'b1000111, SX = 7'b0000000;

  disp_mux #(.DIGITS(4), .DIV(4), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value), .dp(dp),
    .blank_lz(blank_lz), .segments(segments), .seg_dp(seg_dp),
    .digit_sel(digit_sel), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  ds;
    logic [6:0]  seg;
    logic        dp;
    logic        fd;
    string       name;
  } exp_t;

  exp_t q[$];
  int   nchk = 0;
  int   npass = 0;

  task automatic check(input string nm, input logic [12:0] act, input logic [12:0] exp_v);
    nchk++;
    if (act === exp_v) npass++;
    else $display("FAIL %s: got sel=%b seg=%b dp=%b fd=%b, want sel=%b seg=%b dp=%b fd=%b",
                  nm, act[12:9], act[8:2], act[1], act[0],
                  exp_v[12:9], exp_v[8:2], exp_v[1], exp_v[0]);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.cyc < cyc) begin
        nchk++;
        $display("FAIL %s: expectation for cycle %0d expired at cycle %0d", e.name, e.cyc, cyc);
      end else begin
        check(e.name, {digit_sel, segments, seg_dp, frame_done}, {e.ds, e.seg, e.dp, e.fd});
      end
    end
  end

  task automatic push1(input int unsigned c, input logic [3:0] ds, input logic [6:0] seg,
                       input logic dpe, input logic fd, input string nm);
    exp_t e;
    e.cyc = c; e.ds = ds; e.seg = seg; e.dp = dpe; e.fd = fd; e.name = nm;
    q.push_back(e);
  endtask

  task automatic push_off(input int unsigned c, input string nm);
    push1(c, 4'b1111, SX, 1'b0, 1'b0, nm);
  endtask

  // One scan frame starting from idx 0/count 0 at cycle base: 4 cycles per digit.
  task automatic frame(input int unsigned base, input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dpv,
                       input int n, input string nm);
    logic [6:0] s;
    int d;
    for (int k = 0; k < n; k++) begin
      d = k / 4;
      s = (d == 0) ? s0 : (d == 1) ? s1 : (d == 2) ? s2 : s3;
      push1(base + 1 + k, ~(4'(1) << d), s, dpv[d], (k == 15),
            $sformatf("%s d%0d k%0d", nm, d, k));
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_load(input logic [15:0] v, input logic [3:0] d);
    en = 1'b0; load = 1'b1; value = v; dp = d;
    push_off(cyc + 1, "idle_load");
    tick_n(1);
    en = 1'b1; load = 1'b0;
  endtask

  int unsigned base;

  initial begin
    rst_n = 1'b1; en = 1'b0; load = 1'b0; blank_lz = 1'b0; value = '0; dp = '0;
    #1 rst_n = 1'b0;
    #1 check("reset_async", {digit_sel, segments, seg_dp, frame_done}, {4'b1111, SX, 1'b0, 1'b0});
    tick_n(3);
    rst_n = 1'b1;

    idle_load(16'h12AF, 4'b0000);
    base = cyc;
    frame(base, SF, SA, S2, S1, 4'b0000, 16, "scan0");
    frame(base + 16, SF, SA, S2, S1, 4'b0000, 16, "scan1");
    tick_n(32);

    blank_lz = 1'b1;
    idle_load(16'h0050, 4'b0000);
    frame(cyc, S0, S5, SX, SX, 4'b0000, 16, "blank50");
    tick_n(16);
    idle_load(16'h0000, 4'b1010);
    frame(cyc, S0, SX, SX, SX, 4'b1010, 16, "blank00");
    tick_n(16);

    blank_lz = 1'b0;
    idle_load(16'h2222, 4'b0000);
    frame(cyc, S2, S2, S2, S2, 4'b0000, 16, "tear_old");
    tick_n(9);
    load = 1'b1; value = 16'h1111;
    tick_n(1);
    load = 1'b0;
    tick_n(6);
    frame(cyc, S1, S1, S1, S1, 4'b0000, 16, "tear_new");
    tick_n(5);
    load = 1'b1; value = 16'h3333;
    tick_n(1);
    load = 1'b0;
    tick_n(9);
    load = 1'b1; value = 16'h8888;
    tick_n(1);
    load = 1'b0;
    frame(cyc, S8, S8, S8, S8, 4'b0000, 16, "bnd_load");
    tick_n(16);

    base = cyc;
    frame(base, S8, S8, S8, S8, 4'b0000, 6, "en_pre");
    tick_n(6);
    en = 1'b0;
    for (int k = 7; k <= 9; k++) push_off(base + k, "en_off");
    tick_n(3);
    en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      int d;
      d = (k < 2) ? 1 : (k < 6) ? 2 : 3;
      push1(base + 10 + k, ~(4'(1) << d), S8, 1'b0, (k == 9), $sformatf("en_resume k%0d", k));
    end
    tick_n(10);

    base = cyc;
    frame(base, S8, S8, S8, S8, 4'b0000, 13, "mid_pre");
    tick_n(13);
    load = 1'b1; value = 16'h7777;
    tick_n(1);
    load = 1'b0;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) push_off(cyc + k, "mid_rst");
    #1 check("reset_mid", {digit_sel, segments, seg_dp, frame_done}, {4'b1111, SX, 1'b0, 1'b0});
    tick_n(2);
    rst_n = 1'b1;
    frame(cyc, S0, S0, S0, S0, 4'b0000, 16, "post_rst0");
    frame(cyc + 16, S0, S0, S0, S0, 4'b0000, 16, "post_rst1");
    tick_n(32);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      nchk++;
      $display("FAIL %s: expectation for cycle %0d never checked (timeout)", e.name, e.cyc);
    end
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/disp_mux.md
DISP_MUX -- requirements
Module: disp_mux

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  DIGITS, 4, number of multiplexed digits (legal 1..8).
  DIV, 1024, clock cycles each digit is held (legal >= 2).
  SEG_ACTIVE_LOW, 0, 1 inverts segments and seg_dp at the pins.
  DIG_ACTIVE_LOW, 1, 1 inverts digit_sel at the pins.
REQ-002 Ports SHALL be (name, direction, width, meaning):
  clk, in, 1, sole clock, rising edge.
  rst_n, in, 1, asynchronous active-low reset.
  en, in, 1, scan enable.
  load, in, 1, capture value/dp this cycle.
  value, in, 4*DIGITS, hex digits; digit 0 = value[3:0].
  dp, in, DIGITS, decimal point per digit.
  blank_lz, in, 1, leading-zero blanking enable.
  segments, out, 7, segments a..g, bit 6 = a.
  seg_dp, out, 1, decimal point segment.
  digit_sel, out, DIGITS, one-hot digit enable; bit i = digit i.
  frame_done, out, 1, one-cycle pulse at the end of each scan frame.

Function
REQ-003 Decoding SHALL use the following logical patterns (bit 6 = a, 1 = lit): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, c=0001101, d=0111101, E=1001111, F=1000111.
REQ-004 A prescaler SHALL count 0..DIV-1 while en=1; at DIV-1 it wraps to 0 and the digit index advances.
REQ-005 The digit index SHALL count 0..DIGITS-1 and wrap to 0; frame_done SHALL pulse for exactly one cycle on the wrap from DIGITS-1 to 0.
REQ-006 load=1 SHALL capture value/dp into a pending register and set a pending flag; repeated loads within a frame SHALL overwrite the pending data (last load wins).
REQ-007 Pending data SHALL transfer to the active register on the frame-boundary cycle, and the pending flag SHALL clear there; a load in that same cycle SHALL go directly to active.
REQ-008 While en=0, load SHALL write the active register directly.
REQ-009 Outputs SHALL be registered; they SHALL reflect the index and active data of the previous cycle (1-cycle latency).
REQ-010 With blank_lz=1, each zero nibble with only zero nibbles above it SHALL drive segments all-off; digit 0 SHALL never be blanked.
REQ-011 seg_dp SHALL follow dp[index] of the active register regardless of blanking.
REQ-012 With en=0, the prescaler and index SHALL hold, and the cycle after en falls SHALL drive digit_sel, segments and seg_dp all-off; re-enabling SHALL resume from the held index and count.
REQ-013 Exactly one digit_sel bit SHALL be active while en=1 (after the first post-reset cycle).
REQ-014 Polarity parameters SHALL apply only at the output pins; "off" means the inactive logical level after inversion.

Reset
REQ-015 rst_n=0 SHALL immediately clear the prescaler, index, active, pending data and pending flag, and force frame_done=0, digit_sel all-off, segments all-off and seg_dp off, independent of clk.
REQ-016 Reset asserted mid-scan SHALL discard pending data; after release, scanning SHALL start at digit 0, count 0.

Verification (DIGITS=4, DIV=4, SEG_ACTIVE_LOW=0, DIG_ACTIVE_LOW=1)
REQ-017 Reset: rst_n=0 -> digit_sel=1111, segments=0000000, seg_dp=0, frame_done=0 with no clock edge.
REQ-018 Scan: en=0, load 16'h12AF, then en=1 -> digit_sel 1110/1101/1011/0111, each held 4 cycles, showing 1000111, 1110111, 1101101, 0110000; frame_done pulses every 16 cycles.
REQ-019 Blanking: blank_lz=1, value 16'h0050 -> digits 3 and 2 show 0000000, digit 1 shows 1011011, digit 0 shows 1111110; value 16'h0000 -> only digit 0 is lit, showing 1111110.
REQ-020 Tear-free: 16'h2222 active, load 16'h1111 while digit 2 is shown -> digits 2 and 3 still show 1101101; the next frame shows 0110000 on all digits; a load on the boundary cycle takes effect in that frame.
REQ-021 Enable: en=0 during digit 1, count 2 -> next cycle digit_sel=1111; en=1 -> digit 1 resumes and is held for the 2 remaining cycles.
REQ-022 Mid-scan reset: rst_n pulsed during digit 3 with a load pending -> all outputs off; after release, digit 0 shows 1111110.
